// File: rtl/bench_td_loader_if.sv
// Link between the host-facing UART pin and the assembled ALU bench stimulus word.
interface bench_td_loader_if #(
    parameter int TD_WIDTH = 21
);
    logic                rx;
    logic [TD_WIDTH-1:0] td;
    logic                td_valid;
    logic                frame_err;
    logic                busy;

    modport master (input rx, output td, td_valid, frame_err, busy);
    modport slave  (output rx, input td, td_valid, frame_err, busy);
endinterface

// File: rtl/bench_td_loader.sv
// 8N1 UART receiver that assembles LSB-byte-first bytes into the ALU bench td word.
module bench_td_loader #(
    parameter int CLKS_PER_BIT = 16,
    parameter int TD_WIDTH     = 21,
    parameter int TIMEOUT_BITS = 32
) (
    input logic               clock,
    input logic               reset_n,
    bench_td_loader_if.master bus
);
    localparam int NBYTES   = (TD_WIDTH + 7) / 8;
    localparam int IDX_W    = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int CNT_W    = $clog2(CLKS_PER_BIT);
    localparam int TO_LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int TO_W     = $clog2(TO_LIMIT + 1);

    localparam logic [CNT_W-1:0] HALF_M1   = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NBYTES - 1);
    localparam logic [TO_W-1:0]  TO_MAX_M1 = TO_W'(TO_LIMIT - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

    state_t              state_q, state_d;
    logic [1:0]          sync_q, sync_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [2:0]          bit_idx_q, bit_idx_d;
    logic [7:0]          shift_q, shift_d;
    logic [IDX_W-1:0]    byte_idx_q, byte_idx_d;
    logic [TD_WIDTH-1:0] assembly_q, assembly_d;
    logic [TO_W-1:0]     idle_cnt_q, idle_cnt_d;
    logic                word_done_q, word_done_d;
    logic [TD_WIDTH-1:0] td_q, td_d;
    logic                td_valid_q, td_valid_d;
    logic                frame_err_q, frame_err_d;
    logic                busy_q, busy_d;
    logic                rxs;

    assign rxs = sync_q[1];

    always_comb begin
        sync_d      = {sync_q[0], bus.rx};
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        byte_idx_d  = byte_idx_q;
        assembly_d  = assembly_q;
        idle_cnt_d  = idle_cnt_q;
        word_done_d = 1'b0;
        td_d        = td_q;
        td_valid_d  = 1'b0;
        frame_err_d = 1'b0;

        // The word is published one cycle after its last byte lands in the assembly.
        if (word_done_q) begin
            td_d       = assembly_q;
            td_valid_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (!rxs) begin
                    state_d    = START;
                    cnt_d      = '0;
                    idle_cnt_d = '0;
                end else if (byte_idx_q != '0) begin
                    if (idle_cnt_q >= TO_MAX_M1) begin
                        byte_idx_d = '0;
                        idle_cnt_d = '0;
                    end else begin
                        idle_cnt_d = idle_cnt_q + 1'b1;
                    end
                end else begin
                    idle_cnt_d = '0;
                end
            end
            START: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d = '0;
                    if (rxs) begin
                        state_d = IDLE;
                    end else begin
                        state_d   = DATA;
                        bit_idx_d = '0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d     = '0;
                    shift_d   = {rxs, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 1'b1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STOP: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d = '0;
                    if (rxs) begin
                        state_d = IDLE;
                        // Bits of the last byte beyond TD_WIDTH have no slot and fall away here.
                        for (int j = 0; j < TD_WIDTH; j++) begin
                            if (byte_idx_q == IDX_W'(j / 8)) begin
                                assembly_d[j] = shift_q[j % 8];
                            end
                        end
                        if (byte_idx_q == LAST_IDX) begin
                            word_done_d = 1'b1;
                            byte_idx_d  = '0;
                        end else begin
                            byte_idx_d = byte_idx_q + 1'b1;
                        end
                    end else begin
                        state_d     = BREAK;
                        frame_err_d = 1'b1;
                        byte_idx_d  = '0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            BREAK: begin
                if (rxs) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE) || (byte_idx_d != '0);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            sync_q      <= 2'b11;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            byte_idx_q  <= '0;
            assembly_q  <= '0;
            idle_cnt_q  <= '0;
            word_done_q <= 1'b0;
            td_q        <= '0;
            td_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync_q      <= sync_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            byte_idx_q  <= byte_idx_d;
            assembly_q  <= assembly_d;
            idle_cnt_q  <= idle_cnt_d;
            word_done_q <= word_done_d;
            td_q        <= td_d;
            td_valid_q  <= td_valid_d;
            frame_err_q <= frame_err_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.td        = td_q;
    assign bus.td_valid  = td_valid_q;
    assign bus.frame_err = frame_err_q;
    assign bus.busy      = busy_q;
endmodule
